// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states,
// header field layout and command legality.
package router_pkg;

    localparam int MAX_LEN = 63;
    localparam int LEN_W   = 6;
    localparam int DEST_W  = 2;

    // Header byte layout: {len, dest}
    localparam int HDR_DEST_LSB = 0;
    localparam int HDR_DEST_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam logic [DEST_W-1:0] DEST_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HDR,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DEST_W-1:0] dest;
    } tx_cmd_t;

    // Pack a command into its on-wire header byte.
    function automatic logic [7:0] make_hdr(input tx_cmd_t cmd);
        logic [7:0] hdr;
        hdr = '0;
        hdr[HDR_DEST_MSB:HDR_DEST_LSB] = cmd.dest;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = cmd.len;
        return hdr;
    endfunction

    // A command is illegal if it targets the unused port or carries no payload.
    function automatic logic cmd_illegal(input tx_cmd_t cmd);
        return (cmd.dest == DEST_ILLEGAL) || (cmd.len == '0);
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: filled sequentially during FILL and
// drained sequentially during HDR/PAYLOAD. Read data is the byte at the
// read pointer, registered by the consumer.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DEPTH = MAX_LEN + 1,
    parameter int PTR_W = LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr
);

    logic [7:0] mem [DEPTH];

    // Storage write; contents need no reset since pointers gate every read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer update; clr restarts both pointers for the next packet.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router ingress packet transmitter. Buffers a full payload, then emits
// header, payload and XOR parity, holding each byte while the router is
// busy, followed by a fixed inter-packet gap. All outputs are registered.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_LEN    = router_pkg::MAX_LEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [7:0]        pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [7:0]        data_out,
    output logic              tx_done,
    output logic              cmd_err
);

    tx_state_e        state;
    tx_cmd_t          cmd_q;
    tx_cmd_t          cmd_in;
    logic [7:0]       parity;
    logic [3:0]       gap_cnt;

    logic             wr_en;
    logic             rd_en;
    logic             clr;
    logic [7:0]       rd_data;
    logic [LEN_W-1:0] wr_ptr;
    logic [LEN_W-1:0] rd_ptr;
    logic             last_wr;
    logic             last_rd;

    assign cmd_in = '{len: cmd_len, dest: cmd_dest};

    // pl_ready is exactly the registered FILL indicator, so this is a clean accept.
    assign wr_en   = pl_valid && pl_ready;
    assign last_wr = (wr_ptr == cmd_q.len - 1'b1);
    // rd_ptr counts bytes already loaded into data_out; equal to len means the
    // last payload byte is on the wire.
    assign last_rd = (rd_ptr == cmd_q.len);
    assign rd_en   = !busy && ((state == HDR) || (state == PAYLOAD && !last_rd));
    assign clr     = (state == IDLE);

    router_tx_buf #(
        .DEPTH (MAX_LEN + 1),
        .PTR_W (LEN_W)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (pl_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    // Transmit FSM with registered handshakes and byte outputs; busy only
    // gates advancement, so a held byte stays bit-stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            parity    <= '0;
            gap_cnt   <= '0;
            cmd_ready <= 1'b0;
            pl_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_done   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_illegal(cmd_in)) begin
                            cmd_err <= 1'b1;
                        end else begin
                            cmd_q     <= cmd_in;
                            // Parity seeds with the header byte.
                            parity    <= make_hdr(cmd_in);
                            cmd_ready <= 1'b0;
                            pl_ready  <= 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        parity <= parity ^ pl_data;
                        if (last_wr) begin
                            pl_ready  <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_out  <= make_hdr(cmd_q);
                            state     <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (!busy) begin
                        data_out <= rd_data;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (last_rd) begin
                            pkt_valid <= 1'b0;
                            data_out  <= parity;
                            state     <= PARITY;
                        end else begin
                            data_out <= rd_data;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        tx_done  <= 1'b1;
                        data_out <= '0;
                        gap_cnt  <= 4'(GAP_CYCLES - 1);
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter driving the router's ingress byte interface (`pkt_valid`, 8-bit data, `busy`). It accepts a destination/length command and its payload from an upstream source, buffers the whole payload, then emits a protocol-correct packet: header, payload, trailing parity byte. It stalls on router `busy` and enforces an inter-packet gap. It is the source end of the router's input protocol and is used both in the system datapath and as the reference stimulus source in router testbenches.

## Interface
- `GAP_CYCLES`, default 2: idle cycles inserted after each parity byte before the next header may be driven; legal range 1..15.
- `MAX_LEN`, default 63: maximum payload length; fixed by the 6-bit header length field.
- One clock; reset is synchronous and active-high.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_dest`  in  2  destination port 0..2; 3 is illegal.
- `cmd_len`  in  6  payload length 1..63; 0 is illegal.
- `pl_valid`  in  1  payload byte offered.
- `pl_ready`  out  1  payload byte accepted when `pl_valid & pl_ready`.
- `pl_data`  in  8  payload byte.
- `busy`  in  1  router busy; the current output byte is held while high.
- `pkt_valid`  out  1  high for header and payload bytes; low for parity.
- `data_out`  out  8  byte presented to the router `data_in`.
- `tx_done`  out  1  one-cycle pulse when the parity byte is consumed.
- `cmd_err`  out  1  one-cycle pulse when an illegal command is rejected.

## Operation
- States: IDLE, FILL, HDR, PAYLOAD, PARITY, GAP.
- **IDLE**
  - `cmd_ready`=1.
  - On accept with an illegal command (dest==3 or len==0): pulse `cmd_err` next cycle, stay in IDLE.
  - On accept with a legal command: latch dest/len, go to FILL.
- **FILL**
  - `pl_ready`=1 until `len` bytes are accepted into the payload buffer.
  - Gaps in `pl_valid` are allowed.
  - After the last byte, go to HDR.
- **HDR**
  - Drive `data_out={len,dest}` with `pkt_valid`=1.
  - Byte consumed on a cycle with `busy`=0, then go to PAYLOAD.
- **PAYLOAD**
  - Drive buffered bytes in order with `pkt_valid`=1.
  - Each byte advances only on a cycle with `busy`=0.
  - After the last byte is consumed, go to PARITY.
- **PARITY**
  - Drive `data_out`=XOR of header and all payload bytes, with `pkt_valid`=0.
  - Consumed on `busy`=0: pulse `tx_done`, go to GAP.
- **GAP**
  - `pkt_valid`=0, `data_out`=0 for `GAP_CYCLES` cycles, then IDLE.
- `busy` holds `data_out` and `pkt_valid` bit-stable in every state, including PARITY.
- `pkt_valid` never drops between header and last payload byte. Full buffering guarantees this.
- Parity accumulates during FILL. Width is 8 bits, pure XOR, no carry.
- `cmd_ready`=0 outside IDLE. `pl_ready`=0 outside FILL.
- Payload bytes offered outside FILL are ignored (not accepted).

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 the cycle after; all other outputs 0.
- Reset clears state, buffer pointers, parity and gap counter.
- Reset mid-packet drops `pkt_valid` the next cycle; no parity byte is sent.
- Command accepted at cycle N → FILL at N+1. Last payload accept at cycle M → header driven at M+1.
- With `busy`=0 throughout:
  - header at H, payload at H+1..H+len, parity at H+len+1;
  - `tx_done` at H+len+2;
  - `cmd_ready` high at H+len+2+GAP_CYCLES.
- A `busy` rise in the same cycle a byte is presented: that byte is held; no skip, no duplicate.
- `busy` is sampled; no combinational path from `busy` to any output.
- `cmd_ready` and `pl_ready` are registered.

## Structure
- Shared package `router_pkg`: state enum, `MAX_LEN`, header field positions (dest [1:0], len [7:2]), `DEST_ILLEGAL`=2'b11.
- Sub-module `router_tx_buf`: 64x8 payload buffer with write pointer (FILL) and read pointer (PAYLOAD). Pointers clear on `reset` and at IDLE entry.
- Top holds the FSM, parity register, gap counter and output registers.

## Test plan
- dest=1, len=3, payload 0x11,0x22,0x33, `busy`=0 → `data_out` 0x0D,0x11,0x22,0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0; `tx_done` one cycle later.
- Same packet, `busy`=1 for 3 cycles during header and for 2 cycles during parity → each byte held stable, no loss or duplication; same byte sequence.
- dest=3, len=5 → `cmd_err` pulse, no `pkt_valid`; a following legal dest=0, len=1 packet sends normally.
- dest=2, len=63 with random `pl_valid` gaps → `pkt_valid` high for exactly 64 contiguous consumed bytes; parity matches the model.
- `reset` asserted at payload byte 2 of len=10 → all outputs 0 next cycle; a new packet after reset transmits correctly.
- Back-to-back commands with `GAP_CYCLES`=2 → exactly 2 idle cycles between parity and the next command accept.
